// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath (lw, sw, R-type, beq, addi, j).
// Latency: outputs are decoded from the current state; the state moves on each rising clk edge.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0, with no PC, IR or register writes.
//
// Ports: clk, rst_n (async active-low); opcode (IR[31:26]), zero (ALU flag), mem_ready (memory handshake);
//        datapath controls pc_en, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst,
//        reg_write, alu_src_a, pc_source, alu_src_b, alu_op; illegal_op pulse; state (debug).
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] pc_source,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXEC     = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     cur;
    logic [5:0] op_q;          // opcode captured in DECODE; MEMADR picks lw/sw from this copy
    logic       pc_write_int;
    logic       branch_int;
    logic       op_supported;

    always_comb begin
        op_supported = 1'b0;
        case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_supported = 1'b1;
            default:                                       op_supported = 1'b0;
        endcase
    end

    // State register. Codes 12-15 are unreachable in normal operation and recover to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= FETCH;
            op_q <= 6'd0;
        end else begin
            case (cur)
                FETCH:    if (mem_ready) cur <= DECODE;
                DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYPE:     cur <= EXEC;
                        OP_BEQ:       cur <= BRANCH;
                        OP_ADDI:      cur <= ADDIEXEC;
                        OP_J:         cur <= JUMP;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR:   cur <= (op_q == OP_SW) ? MEMWR : MEMRD;
                MEMRD:    if (mem_ready) cur <= MEMWB;
                MEMWR:    if (mem_ready) cur <= FETCH;
                EXEC:     cur <= ALUWB;
                ADDIEXEC: cur <= ADDIWB;
                MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: cur <= FETCH;
                default:  cur <= FETCH;
            endcase
        end
    end

    // Moore output decode. The only input terms are mem_ready in FETCH (IR/PC load on the
    // completing fetch cycle, masked while reset is held) and zero for the branch PC enable.
    always_comb begin
        i_or_d       = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        pc_source    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        pc_write_int = 1'b0;
        branch_int   = 1'b0;
        case (cur)
            FETCH: begin
                mem_read     = 1'b1;
                alu_src_b    = 2'b01;
                ir_write     = mem_ready & rst_n;
                pc_write_int = mem_ready & rst_n;
            end
            DECODE: begin
                alu_src_b = 2'b11;
            end
            MEMADR, ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                branch_int = 1'b1;
            end
            JUMP: begin
                pc_source    = 2'b10;
                pc_write_int = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pc_en      = pc_write_int | (branch_int & zero);
    assign illegal_op = (cur == DECODE) & ~op_supported;
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       illegal_op;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .pc_source  (pc_source),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic [15:0] obs;
    assign obs = {pc_en, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                  alu_src_a, pc_source, alu_src_b, alu_op, illegal_op};

    // Expected per-state control table, written straight from the state descriptions.
    function automatic logic [15:0] exp_outs(input int s, input logic mr, input logic z,
                                              input logic [5:0] op, input logic rn);
        logic pe, iod, irw, mrd, mwr, mtr, rd, rw, asa, pcw, br, ill;
        logic [1:0] ps, asb, aop;
        {pe, iod, irw, mrd, mwr, mtr, rd, rw, asa, pcw, br, ill} = '0;
        {ps, asb, aop} = '0;
        case (s)
            0:  begin mrd = 1; asb = 2'b01; irw = mr & rn; pcw = mr & rn; end
            1:  begin asb = 2'b11;
                      ill = !(op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP); end
            2, 9: begin asa = 1; asb = 2'b10; end
            3:  begin iod = 1; mrd = 1; end
            4:  begin mtr = 1; rw = 1; end
            5:  begin iod = 1; mwr = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
            10: begin rw = 1; end
            11: begin ps = 2'b10; pcw = 1; end
            default: begin end
        endcase
        pe = pcw | (br & z);
        return {pe, iod, irw, mrd, mwr, mtr, rd, rw, asa, ps, asb, aop, ill};
    endfunction

    // Instruction path as a list of visited states (stall repeats added by the runner).
    int path[8];
    int plen;
    function automatic void build_path(input logic [5:0] op);
        path[0] = 0; path[1] = 1; plen = 2;
        case (op)
            LW:   begin path[2] = 2; path[3] = 3; path[4] = 4; plen = 5; end
            SW:   begin path[2] = 2; path[3] = 5; plen = 4; end
            RT:   begin path[2] = 6; path[3] = 7; plen = 4; end
            BEQ:  begin path[2] = 8; plen = 3; end
            ADDI: begin path[2] = 9; path[3] = 10; plen = 4; end
            JMP:  begin path[2] = 11; plen = 3; end
            default: begin end
        endcase
    endfunction

    task automatic check_now(input string tag, input int exp_st);
        logic [3:0] es;
        logic [15:0] eo;
        es = exp_st[3:0];
        eo = exp_outs(exp_st, mem_ready, zero, opcode, rst_n);
        checks++;
        assert (state === es) else begin
            failures++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, es);
        end
        checks++;
        assert (obs === eo) else begin
            failures++;
            $error("FAIL %s outputs observed=%b expected=%b (state %0d)", tag, obs, eo, exp_st);
        end
    endtask

    // Runs one instruction; sf/sm = stall cycles in FETCH and in MEMRD/MEMWR.
    // stop_st >= 0 returns right after checking the first cycle in that state.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                             input int sf, input int sm, input int stop_st);
        int reps;
        build_path(op);
        for (int i = 0; i < plen; i++) begin
            reps = (path[i] == 0) ? sf : ((path[i] == 3 || path[i] == 5) ? sm : 0);
            for (int r = 0; r <= reps; r++) begin
                @(negedge clk);
                opcode = op;
                zero   = z;
                if (reps == 0 && path[i] != 0 && path[i] != 3 && path[i] != 5)
                    mem_ready = 1'($urandom);
                else
                    mem_ready = (r == reps);
                #1;
                check_now(tag, path[i]);
                if (path[i] == stop_st) return;
            end
        end
    endtask

    // Counts DUT cycles from a FETCH until the state next returns to FETCH.
    task automatic measure(input string tag, input logic [5:0] op, input int lat);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            opcode = op;
            mem_ready = 1'b1;
            #1;
            if (cnt > 0 && state == 4'd0) begin
                mem_ready = 1'b0;
                break;
            end
            cnt++;
        end
        checks++;
        assert (cnt === lat) else begin
            failures++;
            $error("FAIL %s latency observed=%0d expected=%0d", tag, cnt, lat);
        end
    endtask

    initial begin
        logic [5:0] rop;
        logic [5:0] ops[6];
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ; ops[4] = ADDI; ops[5] = JMP;

        // Reset held with mem_ready high: FETCH outputs with IR/PC writes masked.
        rst_n = 1'b0; mem_ready = 1'b1; opcode = LW; zero = 1'b1;
        #3;
        check_now("reset_async", 0);
        @(negedge clk); #1;
        check_now("reset_held_edge", 0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;

        run_instr("lw_basic", LW, 1'b0, 0, 0, -1);
        run_instr("beq_taken", BEQ, 1'b1, 0, 0, -1);
        run_instr("beq_not_taken", BEQ, 1'b0, 0, 0, -1);
        run_instr("sw_stall3", SW, 1'b0, 0, 3, -1);
        run_instr("illegal_3f", 6'b111111, 1'b0, 0, 0, -1);
        run_instr("lw_fetch_stall", LW, 1'b1, 2, 2, -1);
        run_instr("rtype_b2b", RT, 1'b0, 0, 0, -1);
        run_instr("addi_b2b", ADDI, 1'b0, 0, 0, -1);
        run_instr("j_b2b", JMP, 1'b1, 0, 0, -1);

        // Asynchronous reset in the middle of ALUWB abandons the write-back.
        run_instr("rtype_to_aluwb", RT, 1'b0, 0, 0, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("reset_mid_aluwb", 0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;

        // Randomized instruction stream, including unsupported opcodes.
        for (int n = 0; n < 40; n++) begin
            rop = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            run_instr("random", rop, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end

        // Latencies with mem_ready held high.
        measure("lat_lw", LW, 5);
        measure("lat_sw", SW, 4);
        measure("lat_rtype", RT, 4);
        measure("lat_addi", ADDI, 4);
        measure("lat_beq", BEQ, 3);
        measure("lat_j", JMP, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
